nonce_uart_tx: RTL and testbench
================================

Name: nonce_uart_tx

Overview:
- Transmit-side counterpart to the work-receive path: accepts 32-bit golden nonces from the hashing core and buffers them in a word FIFO.
- Serializes each nonce onto the UART TX line as 4 byte frames, least-significant byte first.
- Each frame: 1 start bit, 8 data bits LSB-first, STOP_BITS stop bits. No parity.
- Sits between the miner core's result port and the board TX pin; host-side software reassembles 4 bytes per nonce.

Parameters:
- BAUD_RATE, 9600, line rate in bit/s.
- SYS_CLK_FREQ, 100000000, clk frequency in Hz. BAUD_CNT = SYS_CLK_FREQ / BAUD_RATE (integer division) clocks per bit.
- DEPTH, 4, FIFO depth in 32-bit words. Power of two, at least 2.
- STOP_BITS, 1, number of stop bits per frame. Legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  nonce word offered.
- in_ready  out  1  FIFO can accept a word; equals (fifo_level < DEPTH).
- in_word  in  32  nonce; bits [7:0] are sent first.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  clog2(DEPTH+1)  words held in the FIFO, excluding the word being sent.

Behaviour:
- Reset (async assert, sync release): tx=1, in_ready=1, busy=0, fifo_level=0, FIFO pointers 0, FSM=IDLE, bit counters 0.
- Reset mid-frame: tx returns to 1 immediately and all queued words are discarded.
- Push: a word is written on a rising edge where in_valid && in_ready.
  - in_word must be held stable only while in_valid && !in_ready.
  - When full, no push is accepted, even if a pop occurs on the same edge; in_ready rises one clock after the pop.
- Pop: the FSM reads the FIFO head in IDLE (or at the end of the last stop bit of the previous word) when fifo_level>0.
  - Simultaneous push and pop on a non-full FIFO leave fifo_level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when FIFO is non-empty, pop the word into a 32-bit shift register, set byte_idx=0, tx=0, baud counter=BAUD_CNT-1, go to START.
  - Latency: with an empty FIFO, tx falls on the first rising edge after the accepting edge.
  - START: hold tx=0 for BAUD_CNT clocks, then drive tx=bit0 of the current byte and go to DATA with bit_idx=0.
  - DATA: each bit is held exactly BAUD_CNT clocks. After bit 7, drive tx=1 and go to STOP.
  - STOP: hold tx=1 for STOP_BITS*BAUD_CNT clocks, then:
    - if byte_idx<3: byte_idx+1, shift register right 8, tx=0, go to START;
    - else if FIFO non-empty: pop the next word, byte_idx=0, tx=0, go to START (back-to-back, no extra idle);
    - else go to IDLE with tx=1.
- Frame length is exactly (9+STOP_BITS)*BAUD_CNT clocks. A word takes 4x that.
- Baud counter width is clog2(STOP_BITS*BAUD_CNT). It counts down; the bit boundary is at count 0.
- busy = (state != IDLE) || (fifo_level != 0).
- in_valid is ignored while rst_n=0.

Decomposition:
- Shared package holds:
  - FSM state encoding (2 bits: IDLE=0, START=1, DATA=2, STOP=3);
  - a clog2 function;
  - constant BYTES_PER_NONCE=4.
- One natural sub-module: uart_tx_serializer.
  - Owns START/DATA/STOP timing for a single byte.
  - Ports: byte_valid/byte_ready handshake, tx output.
- The top holds the word FIFO and the byte sequencing (byte_idx, shift, pop).

Test Plan:
- Single word, SYS_CLK_FREQ=1000, BAUD_RATE=100 (BAUD_CNT=10), STOP_BITS=1; push 0xA1B2C3D4 -> tx falls 1 clk after the push.
  - Bytes on the line are D4,C3,B2,A1; D4 samples (mid-bit) as 0,0,0,1,0,1,0,1,1,1.
  - Each byte is 100 clks; the word is 400 clks; then tx=1 and busy=0.
- Back-to-back: push 0x00000001 then 0xFFFFFFFF on consecutive clocks -> 800 contiguous clks of frames with no idle between words; fifo_level goes 1 then 0 after the second pop.
- Full FIFO, DEPTH=4: push 6 words while the first is sending -> the 6th push is stalled (in_ready=0 with fifo_level=4); in_ready rises 1 clk after the second pop; all 6 words arrive in order.
- STOP_BITS=2, BAUD_CNT=10: push 0x0000005A -> each frame is 110 clks with 20 high clks between start bits; the word is 440 clks.
- Reset mid-frame: assert rst_n=0 at clk 35 of byte 0 with 2 words queued -> tx=1 immediately; after release, fifo_level=0, busy=0, and no further frames are sent.
- Simultaneous push and pop with fifo_level=1 at the end of the last stop bit -> fifo_level stays 1 and the next start bit begins on the same edge.

Source files
------------

// File: rtl/nonce_uart_tx_pkg.sv
// Shared types and constants for the nonce UART transmit path.
package nonce_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned BYTES_PER_NONCE = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Sends one byte frame (start, 8 data LSB-first, STOP_BITS stop) per byte_valid/byte_ready handshake.
module uart_tx_serializer
  import nonce_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_CNT  = 10416,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx,
  output logic       idle
);

  localparam int unsigned StopCnt = STOP_BITS * BAUD_CNT;
  localparam int unsigned CntW    = (clog2(StopCnt) > 0) ? clog2(StopCnt) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_CNT - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(StopCnt - 1);

  tx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      data_q;
  logic            tx_q;

  // A new byte is taken in idle or on the very last clock of the stop period,
  // so consecutive frames abut with no idle gap.
  assign byte_ready = (state_q == StIdle) || ((state_q == StStop) && (cnt_q == '0));
  assign tx         = tx_q;
  assign idle       = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      data_q  <= byte_data;
      tx_q    <= 1'b0;
      cnt_q   <= BitLast;
      state_q <= StStart;
    end else begin
      unique case (state_q)
        StIdle: ;
        StStart: begin
          if (cnt_q == '0) begin
            tx_q      <= data_q[0];
            bit_idx_q <= '0;
            cnt_q     <= BitLast;
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (bit_idx_q == 3'd7) begin
            tx_q    <= 1'b1;
            cnt_q   <= StopLast;
            state_q <= StStop;
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
            tx_q      <= data_q[1];
            data_q    <= data_q >> 1;
            cnt_q     <= BitLast;
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/nonce_uart_tx.sv
// Word FIFO of 32-bit nonces feeding a byte serializer, least-significant byte first.
module nonce_uart_tx
  import nonce_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_word,
  output logic                         tx,
  output logic                         busy,
  output logic [clog2(DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned BaudCnt = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned PtrW    = clog2(DEPTH);
  localparam int unsigned LvlW    = clog2(DEPTH + 1);

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic [1:0]      bytes_left_q;
  logic [23:0]     shift_q;

  logic       push, pop, handoff;
  logic       byte_valid, byte_ready, ser_idle;
  logic [7:0] byte_data;

  assign in_ready   = (level_q != LvlW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign byte_valid = (bytes_left_q != 2'd0) || (level_q != '0);
  assign byte_data  = (bytes_left_q != 2'd0) ? shift_q[7:0] : mem_q[rd_ptr_q][7:0];
  assign handoff    = byte_valid && byte_ready;
  // The head word is popped only when its first byte goes to the serializer.
  assign pop        = handoff && (bytes_left_q == 2'd0);

  assign busy       = !ser_idle || (level_q != '0);
  assign fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      bytes_left_q <= '0;
      shift_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: ;
      endcase
      if (handoff) begin
        if (bytes_left_q == 2'd0) begin
          shift_q      <= mem_q[rd_ptr_q][31:8];
          bytes_left_q <= 2'(BYTES_PER_NONCE - 1);
        end else begin
          shift_q      <= shift_q >> 8;
          bytes_left_q <= bytes_left_q - 2'd1;
        end
      end
    end
  end

  uart_tx_serializer #(
    .BAUD_CNT  (BaudCnt),
    .STOP_BITS (STOP_BITS)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .tx         (tx),
    .idle       (ser_idle)
  );

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Bench for nonce_uart_tx: two instances (1 and 2 stop bits, 10 clocks per bit) share stimulus.
module tb_nonce_uart_tx;

  localparam int unsigned BC    = 10;
  localparam int unsigned DEPTH = 4;

  logic        clk, rst_n, in_valid;
  logic [31:0] in_word;
  logic        tx0, tx1, rdy0, rdy1, busy0, busy1;
  logic [2:0]  lvl0, lvl1;

  int vectors = 0;
  int miscompares = 0;

  // Model state: per instance a word queue (circular) and the word on the line.
  logic [31:0] mw [2][DEPTH];
  int          mhd [2];
  int          mcnt [2];
  logic        mact [2];
  int          mpos [2];
  logic [31:0] mcur [2];

  nonce_uart_tx #(
    .BAUD_RATE(100), .SYS_CLK_FREQ(1000), .DEPTH(DEPTH), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_word(in_word),
    .tx(tx0), .busy(busy0), .fifo_level(lvl0)
  );

  nonce_uart_tx #(
    .BAUD_RATE(100), .SYS_CLK_FREQ(1000), .DEPTH(DEPTH), .STOP_BITS(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_word(in_word),
    .tx(tx1), .busy(busy1), .fifo_level(lvl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level at position p (clocks since the word's first start bit) for k+1 stop bits.
  function automatic logic exp_line(input int k, input logic [31:0] w, input int p);
    int frame, b, bp;
    frame = (10 + k) * BC;
    b  = p / frame;
    bp = (p % frame) / BC;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return w[b*8 + bp - 1];
    return 1'b1;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mhd[k] = 0; mcnt[k] = 0; mact[k] = 1'b0; mpos[k] = 0; mcur[k] = '0;
    end
  endtask

  task automatic compare_inst(input int k, input logic t, input logic r, input logic b,
                              input logic [2:0] l);
    logic et;
    et = mact[k] ? exp_line(k, mcur[k], mpos[k]) : 1'b1;
    check($sformatf("u%0d tx", k), 32'(t), 32'(et));
    check($sformatf("u%0d in_ready", k), 32'(r), 32'(mcnt[k] < DEPTH));
    check($sformatf("u%0d busy", k), 32'(b), 32'(mact[k] || mcnt[k] != 0));
    check($sformatf("u%0d fifo_level", k), 32'(l), 32'(mcnt[k]));
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare mid-cycle.
  task automatic step();
    logic acc;
    @(posedge clk);
    if (!rst_n) begin
      mreset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        acc = in_valid && (mcnt[k] < DEPTH);
        if (mact[k]) begin
          mpos[k]++;
          if (mpos[k] == 4 * (10 + k) * BC) mact[k] = 1'b0;
        end
        if (!mact[k] && mcnt[k] > 0) begin
          mcur[k] = mw[k][mhd[k]];
          mhd[k]  = (mhd[k] + 1) % DEPTH;
          mcnt[k]--;
          mact[k] = 1'b1;
          mpos[k] = 0;
        end
        if (acc) begin
          mw[k][(mhd[k] + mcnt[k]) % DEPTH] = in_word;
          mcnt[k]++;
        end
      end
    end
    @(negedge clk);
    compare_inst(0, tx0, rdy0, busy0, lvl0);
    compare_inst(1, tx1, rdy1, busy1, lvl1);
  endtask

  task automatic offer(input logic [31:0] w, output int n);
    logic r;
    in_valid = 1'b1;
    in_word  = w;
    n = 0;
    do begin
      r = rdy0;
      step();
      n++;
    end while (!r && n < 3000);
    if (!r) check("offer timeout", 32'(r), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 6000) begin
      step();
      n++;
    end
    check("idle timeout", 32'(busy0 || busy1), 32'd0);
  endtask

  initial begin
    logic [9:0] s0;
    logic [7:0] rx0 [4];
    int n, f, bp;

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0;
    s0 = '0;
    for (int i = 0; i < 4; i++) rx0[i] = '0;
    mreset();
    repeat (3) step();
    check("reset tx", 32'(tx0), 32'd1);
    check("reset level", 32'(lvl0), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single word: latency, bit pattern, byte order, word length.
    in_valid = 1'b1; in_word = 32'hA1B2_C3D4;
    step();
    in_valid = 1'b0;
    check("pre-pop tx", 32'(tx0), 32'd1);
    check("pre-pop level", 32'(lvl0), 32'd1);
    for (int t = 0; t < 450; t++) begin
      step();
      if (t < 400 && (t % 10) == 5) begin
        f  = t / 100;
        bp = (t % 100) / 10;
        if (f == 0) s0[bp] = tx0;
        if (bp >= 1 && bp <= 8) rx0[f][bp-1] = tx0;
      end
      if (t == 0)   check("tx falls 1 clk after push", 32'(tx0), 32'd0);
      if (t == 100) check("u0 byte1 start", 32'(tx0), 32'd0);
      if (t == 105) check("u1 second stop bit", 32'(tx1), 32'd1);
      if (t == 110) check("u1 byte1 start", 32'(tx1), 32'd0);
      if (t == 399) check("u0 busy end of word", 32'(busy0), 32'd1);
      if (t == 400) check("u0 idle after 400", 32'(busy0), 32'd0);
      if (t == 439) check("u1 busy end of word", 32'(busy1), 32'd1);
      if (t == 440) check("u1 idle after 440", 32'(busy1), 32'd0);
    end
    check("D4 mid-bit samples", 32'(s0), 32'h3A8);
    check("byte0", 32'(rx0[0]), 32'hD4);
    check("byte1", 32'(rx0[1]), 32'hC3);
    check("byte2", 32'(rx0[2]), 32'hB2);
    check("byte3", 32'(rx0[3]), 32'hA1);

    // Back-to-back words on consecutive clocks.
    in_valid = 1'b1; in_word = 32'h0000_0001;
    step();
    in_word = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    check("b2b level after first pop", 32'(lvl0), 32'd1);
    for (int t = 1; t <= 420; t++) begin
      step();
      if (t == 399) check("b2b level before second pop", 32'(lvl0), 32'd1);
      if (t == 400) begin
        check("b2b level after second pop", 32'(lvl0), 32'd0);
        check("b2b no idle gap", 32'(tx0), 32'd0);
      end
    end
    wait_idle();

    // Push and pop on the same edge at the end of the last stop bit.
    in_valid = 1'b1; in_word = 32'h1357_9BDF;
    step();
    for (int t = 0; t <= 400; t++) begin
      in_valid = (t == 200) || (t == 400);
      in_word  = (t == 200) ? 32'h0000_005A : 32'hC0DE_F00D;
      step();
      if (t == 400) begin
        check("simul push/pop level", 32'(lvl0), 32'd1);
        check("simul push/pop start", 32'(tx0), 32'd0);
      end
    end
    in_valid = 1'b0;
    wait_idle();

    // Full FIFO: sixth push stalls until one clock after the second pop.
    offer(32'h1111_1111, n);
    offer(32'h2222_2222, n);
    offer(32'h3333_3333, n);
    offer(32'h4444_4444, n);
    offer(32'h5555_5555, n);
    check("full in_ready", 32'(rdy0), 32'd0);
    check("full level", 32'(lvl0), 32'd4);
    offer(32'h6666_6666, n);
    check("stall length", 32'(n), 32'd398);
    wait_idle();

    // Reset in the middle of byte 0 with two words queued.
    offer(32'h1234_5678, n);
    offer(32'h9ABC_DEF0, n);
    offer(32'h0F0F_0F0F, n);
    repeat (34) step();
    check("pre-reset tx low", 32'(tx0), 32'd0);
    check("pre-reset level", 32'(lvl0), 32'd2);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    mreset();
    check("reset u0 tx immediate", 32'(tx0), 32'd1);
    check("reset u1 tx immediate", 32'(tx1), 32'd1);
    check("reset level cleared", 32'(lvl0), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (500) step();
    check("post-reset busy", 32'(busy0), 32'd0);
    check("post-reset level", 32'(lvl0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
